// File: rtl/i2c_arb_pkg.sv
// Shared types and field widths for the I2C command arbiter.
package i2c_arb_pkg;

  localparam int unsigned DEV_ADDR_W = 7;
  localparam int unsigned REG_ADDR_W = 8;
  localparam int unsigned LEN_W      = 8;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } arb_state_e;

endpackage

// File: rtl/i2c_rr_arbiter.sv
// Round-robin requester pick; the search starts at ptr and ptr moves past each accepted grant.
module i2c_rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IdxW = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             accept,
  output logic [N_REQ-1:0] grant,
  output logic [IdxW-1:0]  grant_idx
);

  localparam int unsigned CandW = IdxW + 1;

  logic [IdxW-1:0]  ptr_q, ptr_d;
  logic [CandW-1:0] cand;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr_q} + CandW'(i);
      if (cand >= CandW'(N_REQ)) begin
        cand = cand - CandW'(N_REQ);
      end
      if (!found && req[cand[IdxW-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[IdxW-1:0];
      end
    end
    if (found) begin
      grant = N_REQ'(1) << grant_idx;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (grant_idx == IdxW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Arbitrates N_REQ command requesters onto one I2C master and routes the completion
// status back to the owning requester.
module i2c_cmd_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ-1:0]            req_rw,
  input  logic [DEV_ADDR_W*N_REQ-1:0] req_dev_addr,
  input  logic [REG_ADDR_W*N_REQ-1:0] req_reg_addr,
  input  logic [LEN_W*N_REQ-1:0]      req_len,
  output logic                        m_valid_cmd,
  output logic                        m_rw,
  output logic [DEV_ADDR_W-1:0]       m_dev_addr,
  output logic [REG_ADDR_W-1:0]       m_reg_addr,
  output logic [LEN_W-1:0]            m_len,
  input  logic                        m_done,
  input  logic                        m_error,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic                        rsp_error,
  output logic                        rsp_timeout,
  output logic                        busy
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       owner_q, owner_d;
  logic                  err_q, err_d;
  logic                  to_q, to_d;
  logic                  rw_q, rw_d;
  logic [DEV_ADDR_W-1:0] dev_q, dev_d;
  logic [REG_ADDR_W-1:0] reg_q, reg_d;
  logic [LEN_W-1:0]      len_q, len_d;

  logic                  accept;
  logic [N_REQ-1:0]      grant;
  logic [IdxW-1:0]       grant_idx;

  assign accept = (state_q == StIdle) && (|req_valid) && !rst;

  i2c_rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_rr (
    .clk      (clk),
    .rst      (rst),
    .req      (req_valid),
    .accept   (accept),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    err_d       = err_q;
    to_d        = to_q;
    rw_d        = rw_q;
    dev_d       = dev_q;
    reg_d       = reg_q;
    len_d       = len_q;
    m_valid_cmd = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          owner_d = grant_idx;
          rw_d    = req_rw[grant_idx];
          dev_d   = req_dev_addr[grant_idx*DEV_ADDR_W +: DEV_ADDR_W];
          reg_d   = req_reg_addr[grant_idx*REG_ADDR_W +: REG_ADDR_W];
          len_d   = req_len[grant_idx*LEN_W +: LEN_W];
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d = '0;
        to_d  = 1'b0;
        if (len_q != '0) begin
          m_valid_cmd = !rst;
          state_d     = StWait;
        end else begin
          // A zero-length command is rejected without touching the bus.
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        if (m_error) begin
          err_d   = 1'b1;
          state_d = StResp;
        end else if (m_done) begin
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          to_d    = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      owner_q <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      rw_q    <= 1'b0;
      dev_q   <= '0;
      reg_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      err_q   <= err_d;
      to_q    <= to_d;
      rw_q    <= rw_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      len_q   <= len_d;
    end
  end

  assign req_ready   = accept ? grant : '0;
  assign m_rw        = rw_q;
  assign m_dev_addr  = dev_q;
  assign m_reg_addr  = reg_q;
  assign m_len       = len_q;
  assign rsp_valid   = (state_q == StResp && !rst) ? (N_REQ'(1) << owner_q) : '0;
  assign rsp_error   = (state_q == StResp) && err_q;
  assign rsp_timeout = (state_q == StResp) && to_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Self-checking bench for i2c_cmd_arbiter: vector table, directed corner cases and a
// randomized run against a transaction-level round-robin model.
module tb_i2c_cmd_arbiter;

  localparam int T_MAIN = 64;
  localparam int T_SHORT = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready, t_req_ready;
  logic [3:0]  req_rw;
  logic [27:0] req_dev_addr;
  logic [31:0] req_reg_addr, req_len;
  logic        m_valid_cmd, t_m_valid_cmd;
  logic        m_rw, t_m_rw;
  logic [6:0]  m_dev_addr, t_m_dev_addr;
  logic [7:0]  m_reg_addr, t_m_reg_addr, m_len, t_m_len;
  logic        m_done, m_error;
  logic [3:0]  rsp_valid, t_rsp_valid;
  logic        rsp_error, t_rsp_error, rsp_timeout, t_rsp_timeout, busy, t_busy;

  logic       rw    [4];
  logic [6:0] dev   [4];
  logic [7:0] reg_a [4];
  logic [7:0] len   [4];

  assign req_rw       = {rw[3], rw[2], rw[1], rw[0]};
  assign req_dev_addr = {dev[3], dev[2], dev[1], dev[0]};
  assign req_reg_addr = {reg_a[3], reg_a[2], reg_a[1], reg_a[0]};
  assign req_len      = {len[3], len[2], len[1], len[0]};

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  i2c_cmd_arbiter #(.N_REQ(4), .TIMEOUT_CYCLES(T_MAIN)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_len(req_len),
    .m_valid_cmd(m_valid_cmd), .m_rw(m_rw), .m_dev_addr(m_dev_addr), .m_reg_addr(m_reg_addr),
    .m_len(m_len), .m_done(m_done), .m_error(m_error), .rsp_valid(rsp_valid),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  i2c_cmd_arbiter #(.N_REQ(4), .TIMEOUT_CYCLES(T_SHORT)) dut_t (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(t_req_ready), .req_rw(req_rw),
    .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_len(req_len),
    .m_valid_cmd(t_m_valid_cmd), .m_rw(t_m_rw), .m_dev_addr(t_m_dev_addr),
    .m_reg_addr(t_m_reg_addr), .m_len(t_m_len), .m_done(m_done), .m_error(m_error),
    .rsp_valid(t_rsp_valid), .rsp_error(t_rsp_error), .rsp_timeout(t_rsp_timeout),
    .busy(t_busy)
  );

  typedef struct {
    logic [3:0] mask;
    logic       rw;
    logic [6:0] dev;
    logic [7:0] rega;
    logic [7:0] len;
    int         k;
    bit         dn;
    bit         er;
    int         exp_g;
    bit         exp_er;
    bit         exp_to;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_all(input logic r, input logic [6:0] d, input logic [7:0] ra,
                         input logic [7:0] l);
    for (int i = 0; i < 4; i++) begin
      rw[i] = r; dev[i] = d; reg_a[i] = ra; len[i] = l;
    end
  endtask

  task automatic rand_fields(input int i);
    rw[i]    = 1'($urandom);
    dev[i]   = 7'($urandom);
    reg_a[i] = 8'($urandom);
    len[i]   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
  endtask

  // Spec-level round-robin: first valid index at or after p, modulo 4.
  function automatic int rr_pick(input logic [3:0] m, input int p);
    for (int i = 0; i < 4; i++) begin
      if (m[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  // Entered with the DUT idle and inputs already applied; returns at the response cycle.
  task automatic run_txn(input int g, input int k, input bit dn, input bit er,
                         input bit exp_er, input bit exp_to, input string tag);
    logic [23:0] f;
    logic [3:0]  early;
    int          r;
    f = {rw[g], dev[g], reg_a[g], len[g]};
    if (len[g] == 8'd0) r = 1;
    else if (k <= T_MAIN && (dn || er)) r = k + 1;
    else r = T_MAIN + 1;
    @(negedge clk);
    check({tag, " ready"}, req_ready, 32'(1 << g));
    check({tag, " idle busy"}, busy, 0);
    @(posedge clk); #1;
    req_valid[g] = 1'b0;
    rand_fields(g);
    @(negedge clk);
    check({tag, " m_valid_cmd"}, m_valid_cmd, (f[7:0] != 0));
    if (f[7:0] != 0) check({tag, " fields"}, {m_rw, m_dev_addr, m_reg_addr, m_len}, f);
    early = '0;
    for (int c = 1; c < r; c++) begin
      @(posedge clk); #1;
      m_done  = dn && (c == k);
      m_error = er && (c == k);
      @(negedge clk);
      early = early | rsp_valid | req_ready | {3'b0, m_valid_cmd};
    end
    @(posedge clk); #1;
    m_done = 1'b0; m_error = 1'b0;
    @(negedge clk);
    check({tag, " quiet while busy"}, early, 0);
    check({tag, " rsp_valid"}, rsp_valid, 32'(1 << g));
    check({tag, " rsp_error"}, rsp_error, exp_er);
    check({tag, " rsp_timeout"}, rsp_timeout, exp_to);
    check({tag, " fields stable"}, {m_rw, m_dev_addr, m_reg_addr, m_len}, f);
    check({tag, " no accept in resp"}, req_ready, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] add;
    int g, k, mode, cnt, ptr_m;
    bit dn, er, tmo, ee, got;
    logic [3:0] seen;

    tbl[0]  = '{4'hf, 1'b0, 7'h11, 8'h21, 8'd1,   2,  1'b1, 1'b0, 0, 1'b0, 1'b0};
    tbl[1]  = '{4'hf, 1'b1, 7'h12, 8'h22, 8'd2,   4,  1'b1, 1'b0, 1, 1'b0, 1'b0};
    tbl[2]  = '{4'hf, 1'b0, 7'h13, 8'h23, 8'd4,   1,  1'b0, 1'b1, 2, 1'b1, 1'b0};
    tbl[3]  = '{4'hf, 1'b1, 7'h14, 8'h24, 8'd8,   3,  1'b1, 1'b1, 3, 1'b1, 1'b0};
    tbl[4]  = '{4'hf, 1'b0, 7'h15, 8'h25, 8'd16,  6,  1'b1, 1'b0, 0, 1'b0, 1'b0};
    tbl[5]  = '{4'h4, 1'b0, 7'h50, 8'h10, 8'd3,   19, 1'b1, 1'b0, 2, 1'b0, 1'b0};
    tbl[6]  = '{4'h3, 1'b1, 7'h2a, 8'h77, 8'd5,   5,  1'b1, 1'b1, 0, 1'b1, 1'b0};
    tbl[7]  = '{4'h8, 1'b0, 7'h3c, 8'h80, 8'd9,   1,  1'b0, 1'b1, 3, 1'b1, 1'b0};
    tbl[8]  = '{4'h2, 1'b1, 7'h44, 8'h01, 8'd0,   1,  1'b1, 1'b0, 1, 1'b1, 1'b0};
    tbl[9]  = '{4'h3, 1'b1, 7'h7f, 8'hff, 8'd255, 64, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    tbl[10] = '{4'h9, 1'b0, 7'h01, 8'h02, 8'd7,   70, 1'b0, 1'b0, 3, 1'b1, 1'b1};

    rst = 1'b1; m_done = 1'b0; m_error = 1'b0;
    set_all(1'b1, 7'h7f, 8'hff, 8'hff);
    req_valid = 4'hf;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", req_ready, 0);
    check("reset m_valid_cmd", m_valid_cmd, 0);
    check("reset m fields", {m_rw, m_dev_addr, m_reg_addr, m_len}, 0);
    check("reset rsp", {rsp_valid, rsp_error, rsp_timeout}, 0);
    check("reset busy", {busy, t_busy}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      req_valid = tbl[i].mask;
      set_all(tbl[i].rw, tbl[i].dev, tbl[i].rega, tbl[i].len);
      run_txn(tbl[i].exp_g, tbl[i].k, tbl[i].dn, tbl[i].er, tbl[i].exp_er, tbl[i].exp_to,
              $sformatf("vec%0d", i));
      @(posedge clk); #1;
    end

    // Timeout on the short-timeout instance, then a stray m_done after it.
    rst = 1'b1; req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 4'b0001;
    set_all(1'b0, 7'h21, 8'h33, 8'd5);
    @(negedge clk);
    check("to ready", t_req_ready, 1);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("to m_valid_cmd", t_m_valid_cmd, 1);
    cnt = 0; got = 1'b0;
    while (!got && cnt < 30) begin
      @(posedge clk); #1;
      cnt++;
      @(negedge clk);
      if (t_rsp_valid != 0) got = 1'b1;
    end
    check("to latency", cnt, 11);
    check("to rsp", {t_rsp_valid, t_rsp_error, t_rsp_timeout}, {4'b0001, 1'b1, 1'b1});
    @(posedge clk); #1;
    m_done = 1'b1;
    @(posedge clk); #1;
    m_done = 1'b0;
    seen = '0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | t_rsp_valid;
      @(posedge clk); #1;
    end
    check("to late done ignored", {seen, t_busy}, 0);

    // Reset while waiting on the master: command is dropped and the pointer restarts.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 4'b0100;
    set_all(1'b0, 7'h50, 8'h10, 8'd4);
    @(negedge clk);
    check("rw ready", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid = 4'b1010;
    @(negedge clk);
    check("rw m_valid_cmd", m_valid_cmd, 1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rw outputs cleared",
          {req_ready, m_valid_cmd, m_rw, m_dev_addr, m_reg_addr, m_len, rsp_valid, rsp_error,
           rsp_timeout, busy}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_txn(1, 2, 1'b1, 1'b0, 1'b0, 1'b0, "post-rst");
    @(posedge clk); #1;

    // Randomized traffic against the round-robin model.
    rst = 1'b1; req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    ptr_m = 0;
    for (int n = 0; n < 60; n++) begin
      add = 4'($urandom_range(0, 15)) & ~req_valid;
      if ((req_valid | add) == 4'b0) add = 4'(1 << $urandom_range(0, 3));
      for (int i = 0; i < 4; i++) if (add[i]) rand_fields(i);
      req_valid = req_valid | add;
      g    = rr_pick(req_valid, ptr_m);
      mode = $urandom_range(0, 3);
      dn   = (mode == 0 || mode == 2);
      er   = (mode == 1 || mode == 2);
      k    = $urandom_range(1, 70);
      tmo  = (len[g] != 0) && !(k <= T_MAIN && (dn || er));
      ee   = (len[g] == 0) || tmo || (er && k <= T_MAIN);
      run_txn(g, k, dn, er, ee, tmo, $sformatf("rand%0d", n));
      ptr_m = (g + 1) % 4;
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_arbiter.md
I2C_CMD_ARBITER -- requirements
Module: i2c_cmd_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 65535, maximum clk cycles to wait for master completion (1..2^20-1).
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 req_valid  input  N_REQ  per-requester command request; held until accepted.
REQ-006 req_ready  output  N_REQ  one-hot single-cycle accept pulse.
REQ-007 req_rw  input  N_REQ  per-requester direction, 0 write, 1 read.
REQ-008 req_dev_addr  input  7*N_REQ  per-requester 7-bit device address, requester i at bits [7i+6:7i].
REQ-009 req_reg_addr  input  8*N_REQ  per-requester register address.
REQ-010 req_len  input  8*N_REQ  per-requester byte count.
REQ-011 m_valid_cmd  output  1  single-cycle command strobe to I2C master.
REQ-012 m_rw / m_dev_addr / m_reg_addr / m_len  output  1/7/8/8  latched command fields to master.
REQ-013 m_done  input  1  master completed transfer (stop issued), single-cycle pulse.
REQ-014 m_error  input  1  master NACK/error indication, single-cycle pulse.
REQ-015 rsp_valid  output  N_REQ  one-hot single-cycle completion pulse to owning requester.
REQ-016 rsp_error  output  1  qualifies rsp_valid: 1 = failed.
REQ-017 rsp_timeout  output  1  qualifies rsp_valid: 1 = failure caused by timeout (implies rsp_error).
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-020 IDLE: when any req_valid is set, arbitrate, pulse req_ready[g] in the same cycle, latch g's fields into m_* registers, and go to ISSUE; otherwise stay.
REQ-021 Arbitration SHALL be round-robin: search starts at index ptr, wraps modulo N_REQ, and the first set req_valid wins.
REQ-022 ptr SHALL update to (g+1) mod N_REQ on each accept; wrap from N_REQ-1 goes to 0.
REQ-023 ISSUE: if latched len != 0, assert m_valid_cmd for exactly one cycle, clear timeout counter, and go to WAIT.
REQ-024 ISSUE with latched len == 0: no m_valid_cmd; go to RESP with rsp_error=1, rsp_timeout=0.
REQ-025 WAIT: the counter increments each cycle; on m_error go to RESP with error=1; on m_done alone go to RESP with error=0.
REQ-026 m_done and m_error in the same cycle SHALL report error=1.
REQ-027 WAIT: when the counter reaches TIMEOUT_CYCLES with neither m_done nor m_error, go to RESP with rsp_error=1, rsp_timeout=1.
REQ-028 m_done/m_error outside WAIT SHALL be ignored.
REQ-029 RESP: pulse rsp_valid[g] for one cycle with registered rsp_error/rsp_timeout, then go to IDLE.
REQ-030 Latency: accept at cycle T, m_valid_cmd at T+1, completion seen at D, rsp_valid at D+1, next accept no earlier than D+2.
REQ-031 m_* fields SHALL stay stable from ISSUE until leaving RESP.
REQ-032 req_valid deasserted by a requester after acceptance SHALL NOT affect the in-flight command.
REQ-033 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1).

Reset
REQ-034 rst SHALL force state=IDLE, ptr=0, counter=0, and all outputs to 0 (req_ready, m_valid_cmd, m_* fields, rsp_*, busy).
REQ-035 rst mid-transaction SHALL abandon the command with no rsp_valid; the next cycle is IDLE.

Structure
REQ-036 Package i2c_arb_pkg SHALL hold the FSM state enum and field-width constants (DEV_ADDR_W=7, REG_ADDR_W=8, LEN_W=8).
REQ-037 Sub-module i2c_rr_arbiter SHALL hold the combinational round-robin pick plus the ptr register (inputs req vector and accept enable; output one-hot grant and index).

Verification
REQ-038 N_REQ=4, only req 2 valid (write, dev 0x50, reg 0x10, len 3): req_ready[2] at T, m_valid_cmd at T+1 with those fields; m_done at T+20 -> rsp_valid[2] at T+21, rsp_error=0.
REQ-039 All four valid continuously, each completes: grant order 0,1,2,3,0; ptr wrap verified.
REQ-040 m_error and m_done in the same WAIT cycle -> rsp_error=1, rsp_timeout=0.
REQ-041 TIMEOUT_CYCLES=10, no completion -> rsp_valid with rsp_error=1, rsp_timeout=1 exactly 11 cycles after m_valid_cmd; a later m_done pulse is ignored.
REQ-042 len=0 request -> no m_valid_cmd, rsp_valid 2 cycles after accept with rsp_error=1.
REQ-043 rst asserted during WAIT -> all outputs 0 next cycle, no rsp_valid, ptr=0, and the next grant goes to lowest valid index.
